// File: rtl/dram_arbiter.sv
// Two-port request/acknowledge arbiter sharing a single-port DRAM between
// the processor core (port 0) and the image loader/DMA (port 1).
// Each transaction takes IDLE -> ACCESS -> ACK, so there is at most one
// access every three cycles.
module dram_arbiter #(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 8,
  parameter int FIXED_PRIORITY = 0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q,
  output logic              busy,
  output logic              grant_id
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   last_served;
  logic   winner;
  logic   grant;

  assign busy = (state != IDLE);

  // Winner selection and next-state logic
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    if (req0 && req1)
      winner = (FIXED_PRIORITY != 0) ? 1'b0 : ~last_served;
    else
      winner = ~req0;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          grant     = 1'b1;
          state_nxt = ACCESS;
        end
      end
      ACCESS:  state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // DRAM bus registers, ack pulses and read-data capture
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem_address <= '0;
      mem_data    <= '0;
      mem_wren    <= 1'b0;
      ack0        <= 1'b0;
      ack1        <= 1'b0;
      rdata0      <= '0;
      rdata1      <= '0;
      grant_id    <= 1'b0;
      last_served <= 1'b1;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      if (grant) begin
        mem_address <= winner ? addr1  : addr0;
        mem_data    <= winner ? wdata1 : wdata0;
        mem_wren    <= winner ? we1    : we0;
        grant_id    <= winner;
        last_served <= winner;
      end
      if (state == ACCESS) begin
        // The DRAM completed the access on the falling edge just passed,
        // so mem_q already holds the read result here.
        mem_wren <= 1'b0;
        if (grant_id) begin
          ack1 <= 1'b1;
          if (!mem_wren) rdata1 <= mem_q;
        end else begin
          ack0 <= 1'b1;
          if (!mem_wren) rdata0 <= mem_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_dram_arbiter.sv
// Bench for dram_arbiter: one round-robin and one fixed-priority instance,
// each with its own falling-edge DRAM model, checked against a
// transaction-level reference model.
module tb_dram_arbiter;

  logic clock = 1'b0;
  logic reset_n;

  logic [1:0]       req0, we0, req1, we1;
  logic [1:0][15:0] addr0, addr1;
  logic [1:0][7:0]  wdata0, wdata1;
  logic [1:0]       ack0, ack1, mem_wren, busy, grant_id;
  logic [1:0][7:0]  rdata0, rdata1, mem_data;
  logic [1:0][15:0] mem_address;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state, per instance and per port
  logic [7:0]  ref_mem [2][128];
  bit          last_s  [2];
  bit          p_req   [2][2];
  bit          p_we    [2][2];
  logic [15:0] p_addr  [2][2];
  logic [7:0]  p_wd    [2][2];
  logic [7:0]  exp_rd  [2][2];

  always #5 clock = ~clock;

  function automatic logic [7:0] init_val(input logic [6:0] a);
    case (a)
      7'd0, 7'd1, 7'd3, 7'd4: init_val = 8'hA1;
      7'd2:                   init_val = 8'h9D;
      7'd5:                   init_val = 8'h9F;
      default:                init_val = {a, 1'b0} ^ 8'h3C;
    endcase
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [7:0] q;
    logic [7:0] dram [128];

    dram_arbiter #(
      .ADDR_W(16),
      .DATA_W(8),
      .FIXED_PRIORITY(g)
    ) u_dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .req0        (req0[g]),
      .we0         (we0[g]),
      .addr0       (addr0[g]),
      .wdata0      (wdata0[g]),
      .ack0        (ack0[g]),
      .rdata0      (rdata0[g]),
      .req1        (req1[g]),
      .we1         (we1[g]),
      .addr1       (addr1[g]),
      .wdata1      (wdata1[g]),
      .ack1        (ack1[g]),
      .rdata1      (rdata1[g]),
      .mem_address (mem_address[g]),
      .mem_data    (mem_data[g]),
      .mem_wren    (mem_wren[g]),
      .mem_q       (q),
      .busy        (busy[g]),
      .grant_id    (grant_id[g])
    );

    // Single-port DRAM acting on the falling edge
    initial begin
      q = '0;
      for (int unsigned a = 0; a < 128; a++) dram[a] = init_val(7'(a));
      forever begin
        @(negedge clock);
        q = dram[mem_address[g][6:0]];
        if (mem_wren[g]) dram[mem_address[g][6:0]] = mem_data[g];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic apply(input int d);
    req0[d]   = p_req[d][0];
    we0[d]    = p_we[d][0];
    addr0[d]  = p_addr[d][0];
    wdata0[d] = p_wd[d][0];
    req1[d]   = p_req[d][1];
    we1[d]    = p_we[d][1];
    addr1[d]  = p_addr[d][1];
    wdata1[d] = p_wd[d][1];
  endtask

  task automatic set_req(input int d, input int p, input bit r, input bit we,
                         input logic [15:0] a, input logic [7:0] wd);
    p_req[d][p]  = r;
    p_we[d][p]   = we;
    p_addr[d][p] = a;
    p_wd[d][p]   = wd;
  endtask

  task automatic new_req(input int d, input int p);
    set_req(d, p, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
            16'($urandom_range(0, 127)), 8'($urandom));
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      last_s[d] = 1'b1;
      for (int p = 0; p < 2; p++) begin
        set_req(d, p, 1'b0, 1'b0, '0, '0);
        exp_rd[d][p] = '0;
      end
    end
  endtask

  // One arbitration slot, entered #1 after a rising edge with the DUT idle
  // and the pending requests already driven. Returns the winner or -1.
  task automatic run_txn(input int d, output int w);
    int a;
    if (!p_req[d][0] && !p_req[d][1]) begin
      w = -1;
      @(posedge clock); #1;
      check("idle_busy", busy[d], 0);
      check("idle_wren", mem_wren[d], 0);
      check("idle_ack", {ack1[d], ack0[d]}, 0);
      return;
    end
    if (p_req[d][0] && p_req[d][1]) w = (d == 1) ? 0 : (last_s[d] ? 0 : 1);
    else                            w = p_req[d][0] ? 0 : 1;
    a = int'(p_addr[d][w][6:0]);

    @(posedge clock); #1;
    check("grant_id", grant_id[d], w);
    check("busy_access", busy[d], 1);
    check("mem_address", mem_address[d], p_addr[d][w]);
    check("mem_wren_on", mem_wren[d], p_we[d][w]);
    if (p_we[d][w]) check("mem_data", mem_data[d], p_wd[d][w]);
    check("ack_early", {ack1[d], ack0[d]}, 0);
    last_s[d] = w[0];
    if (p_we[d][w]) ref_mem[d][a] = p_wd[d][w];
    else            exp_rd[d][w]  = ref_mem[d][a];

    @(posedge clock); #1;
    check("ack_pulse", {ack1[d], ack0[d]}, (w == 1) ? 2'b10 : 2'b01);
    check("rdata0", rdata0[d], exp_rd[d][0]);
    check("rdata1", rdata1[d], exp_rd[d][1]);
    check("mem_wren_off", mem_wren[d], 0);
    check("busy_ack", busy[d], 1);

    @(posedge clock); #1;
    check("ack_clear", {ack1[d], ack0[d]}, 0);
    check("busy_idle", busy[d], 0);
    check("grant_hold", grant_id[d], w);
  endtask

  initial begin
    int w;
    reset_n = 1'b0;
    model_reset();
    for (int d = 0; d < 2; d++) begin
      apply(d);
      for (int a = 0; a < 128; a++) ref_mem[d][a] = init_val(7'(a));
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      check("rst_outputs", {ack0[d], ack1[d], mem_wren[d], busy[d], grant_id[d]}, 0);
      check("rst_rdata", {rdata0[d], rdata1[d]}, 0);
      check("rst_bus", {mem_address[d], mem_data[d]}, 0);
    end
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;

    // Port 0 read of address 0
    set_req(0, 0, 1, 0, 16'h0000, 8'h00); apply(0);
    run_txn(0, w);
    check("tp_rd0", rdata0[0], 8'hA1);
    set_req(0, 0, 0, 0, 16'h0000, 8'h00); apply(0);

    // Port 1 write then read of 0x0040
    set_req(0, 1, 1, 1, 16'h0040, 8'h5A); apply(0);
    run_txn(0, w);
    set_req(0, 1, 1, 0, 16'h0040, 8'h00); apply(0);
    run_txn(0, w);
    check("tp_wr_rd1", rdata1[0], 8'h5A);
    set_req(0, 1, 0, 0, 16'h0040, 8'h00); apply(0);

    // Round-robin contention
    set_req(0, 0, 1, 0, 16'h0001, 8'h00);
    set_req(0, 1, 1, 0, 16'h0002, 8'h00); apply(0);
    for (int i = 0; i < 4; i++) begin
      run_txn(0, w);
      check("tp_rr_order", grant_id[0], i % 2);
    end
    check("tp_rr_rd0", rdata0[0], 8'hA1);
    check("tp_rr_rd1", rdata1[0], 8'h9D);
    model_reset_pending(0);

    // Fixed-priority contention
    set_req(1, 0, 1, 0, 16'h0003, 8'h00);
    set_req(1, 1, 1, 0, 16'h0002, 8'h00); apply(1);
    for (int i = 0; i < 3; i++) begin
      run_txn(1, w);
      check("tp_fp_order", grant_id[1], 0);
    end
    set_req(1, 0, 0, 0, 16'h0003, 8'h00); apply(1);
    run_txn(1, w);
    check("tp_fp_p1", grant_id[1], 1);
    check("tp_fp_rd1", rdata1[1], 8'h9D);
    model_reset_pending(1);

    // Back-to-back port 0 reads with req0 held
    set_req(0, 0, 1, 0, 16'h0003, 8'h00); apply(0);
    run_txn(0, w);
    set_req(0, 0, 1, 0, 16'h0004, 8'h00); apply(0);
    run_txn(0, w);
    check("tp_b2b_rd0", rdata0[0], 8'hA1);
    model_reset_pending(0);

    // Reset while a write is in ACCESS, before the falling edge
    set_req(0, 0, 1, 1, 16'h0005, 8'hFF); apply(0);
    @(posedge clock); #1;
    check("tp_rst_wren_pre", mem_wren[0], 1);
    reset_n = 1'b0;
    #1;
    check("tp_rst_wren", mem_wren[0], 0);
    check("tp_rst_busy", busy[0], 0);
    model_reset();
    apply(0); apply(1);
    repeat (2) begin
      @(posedge clock); #1;
      check("tp_rst_noack", {ack1[0], ack0[0]}, 0);
    end
    reset_n = 1'b1;
    set_req(0, 0, 1, 0, 16'h0005, 8'h00); apply(0);
    run_txn(0, w);
    check("tp_rst_rd", rdata0[0], 8'h9F);
    model_reset_pending(0);

    // Randomized traffic on both instances
    for (int d = 0; d < 2; d++) begin
      new_req(d, 0); new_req(d, 1); apply(d);
      for (int i = 0; i < 150; i++) begin
        run_txn(d, w);
        if (w >= 0) new_req(d, w);
        else begin new_req(d, 0); new_req(d, 1); end
        apply(d);
      end
      model_reset_pending(d);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  task automatic model_reset_pending(input int d);
    set_req(d, 0, 0, 0, '0, '0);
    set_req(d, 1, 0, 0, '0, '0);
    apply(d);
  endtask

endmodule

// File: doc/dram_arbiter.md
Name: dram_arbiter

Overview:
Two-port request/acknowledge arbiter that shares the single-port DRAM between the processor core (port 0) and the image loader/DMA (port 1). It serialises accesses, drives the DRAM address/data/wren bus from registers, and returns read data to the winning requester with a one-cycle ack pulse. The arbiter runs on the rising edge. The DRAM performs its access on the falling edge of the same cycle, and the arbiter captures q on the following rising edge.

Parameters:
ADDR_W, 16, DRAM address width
DATA_W, 8, DRAM data width
FIXED_PRIORITY, 0, 0 = round-robin; 1 = port 0 always wins ties

Ports:
clock  in  1  system clock; all arbiter state updates on the rising edge
reset_n  in  1  asynchronous, active-low reset
req0  in  1  core request; held high until ack0 is sampled
we0  in  1  core write enable (1 = write, 0 = read); stable while req0 is high
addr0  in  ADDR_W  core address; stable while req0 is high
wdata0  in  DATA_W  core write data; stable while req0 is high
ack0  out  1  one-cycle pulse marking completion of the core transaction
rdata0  out  DATA_W  core read data; valid when ack0 is high, held until the next port-0 read
req1, we1, addr1, wdata1  in  1/1/ADDR_W/DATA_W  loader request fields; same rules as port 0
ack1, rdata1  out  1/DATA_W  loader completion and read data
mem_address  out  ADDR_W  to DRAM address
mem_data  out  DATA_W  to DRAM data
mem_wren  out  1  to DRAM wren
mem_q  in  DATA_W  from DRAM q
busy  out  1  high whenever the state is not IDLE
grant_id  out  1  port currently or last served

Behaviour:
- Reset, asynchronous, takes effect immediately:
  - state = IDLE
  - mem_wren, mem_address, mem_data, ack0, ack1, rdata0, rdata1 = 0
  - busy = 0, grant_id = 0
  - last_served = 1, so port 0 wins the first tie
- States: IDLE, ACCESS, ACK.
- IDLE: at a rising edge with any req high:
  - Select the winner.
  - Register its addr to mem_address, wdata to mem_data, we to mem_wren.
  - Set grant_id = winner and move to ACCESS.
  - With no req high: remain in IDLE; mem_wren stays 0.
- Winner selection:
  - Only one req high: that port wins.
  - Both high with FIXED_PRIORITY=1: port 0 wins.
  - Both high with FIXED_PRIORITY=0: the port that is not last_served wins.
  - last_served updates to the winner when the grant is issued.
- ACCESS: the DRAM performs the read or write on the falling edge inside this cycle. At the next rising edge:
  - Winner's ack goes to 1.
  - If the access was a read, the winner's rdata captures mem_q. On a write, rdata is unchanged.
  - mem_wren goes to 0 and the state moves to ACK.
- ACK: the ack is high for exactly this one cycle. req lines are not evaluated in ACK. At the next rising edge, ack goes to 0 and the state moves to IDLE.
- Transaction timing:
  - Grant edge T0; ack high in the T1–T2 cycle; next arbitration at T3.
  - Peak throughput is one access per 3 cycles.
  - Latency from a req seen in IDLE to the ack edge is 2 cycles.
- Requester contract:
  - A requester samples ack=1 at T2 and deasserts or changes its request so the new value is valid by T3.
  - req still high at T3 is treated as a new transaction (back-to-back is legal).
  - The fields are captured at grant, so requester changes after grant do not affect the access in flight.
- Non-winner requests stay pending with no timeout. With round-robin, two continuously requesting ports strictly alternate.
- mem_address and mem_data hold their last values in IDLE and ACK. Only mem_wren returns to 0.
- Reset mid-operation: mem_wren clears asynchronously. A write in flight whose falling edge has not yet occurred is aborted. DRAM contents are never cleared by this block. No ack is issued for the aborted transaction.
- ack0 and ack1 are never high in the same cycle.

Test Plan:
- Read, port 0 only: req0=1, we0=0, addr0=0x0000, DRAM[0]=0xA1 -> mem_address=0x0000 after grant; ack0 high for 1 cycle, 2 cycles after grant sampling; rdata0=0xA1; ack1 stays 0.
- Write then read, port 1: write 0x5A to 0x0040, then read 0x0040 -> mem_wren=1 for exactly one cycle; ack1 pulses twice, 3 cycles apart; second pulse has rdata1=0x5A.
- Contention, round-robin: req0 and req1 held high for 4 transactions, reading 0x0001 and 0x0002 -> grant order 0,1,0,1; rdata0=0xA1; rdata1=0x9D.
- Contention with FIXED_PRIORITY=1: both ports held high for 3 transactions -> port 0 serves all 3; port 1 is served on the first IDLE edge after req0 drops.
- Reset during ACCESS of a write of 0xFF to 0x0005 (DRAM[5]=0x9F), with reset_n asserted before the falling edge -> mem_wren=0 at once; no ack; after release, reading 0x0005 returns 0x9F.
- Back-to-back port 0 reads of 0x0003 then 0x0004 with req0 held -> acks 3 cycles apart; rdata0=0xA1 then 0xA1; busy drops for exactly one IDLE cycle between them.
